// File: rtl/red_pitaya_daisy_deframer.sv
// Daisy-chain RX word deframer: hunts for the training word in the serial stream,
// confirms alignment over several word boundaries, then emits aligned parallel words.
module red_pitaya_daisy_deframer #(
    parameter int unsigned     DW        = 16,
    parameter logic [DW-1:0]   TRAIN_PAT = 16'h00FF,
    parameter int unsigned     TRAIN_CNT = 4
) (
    input  logic          ser_clk_i,
    input  logic          ser_rstn_i,
    input  logic          ser_en_i,
    input  logic          ser_dat_i,
    input  logic          cfg_en_i,
    input  logic          cfg_train_i,
    output logic          cfg_trained_o,
    output logic          par_dv_o,
    output logic [DW-1:0] par_dat_o,
    input  logic          stat_clr_i,
    output logic [31:0]   stat_word_o,
    output logic [31:0]   stat_err_o
);

    localparam int unsigned FW = $clog2(DW + 1);
    localparam int unsigned BW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HUNT,
        S_VERIFY,
        S_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] sr_q, sr_d, sr_nxt;
    logic [FW-1:0] fill_q, fill_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]    match_cnt_q, match_cnt_d;
    logic          trained_q, trained_d;
    logic          dv_q, dv_d;
    logic [DW-1:0] dat_q, dat_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   err_q, err_d;
    logic          fill_full, pat_hit, boundary, bump_err;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        sr_nxt      = ser_en_i ? {sr_q[DW-2:0], ser_dat_i} : sr_q;
        sr_d        = sr_nxt;
        // Full counting the current strobe keeps reset zeros from completing a fake pattern.
        fill_full   = ser_en_i && (fill_q >= FW'(DW - 1));
        pat_hit     = fill_full && (sr_nxt == TRAIN_PAT);
        boundary    = ser_en_i && (bit_cnt_q == BW'(DW - 1));
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        match_cnt_d = match_cnt_q;
        dv_d        = 1'b0;
        dat_d       = dat_q;
        bump_err    = 1'b0;

        if (state_q == S_IDLE) begin
            fill_d = '0;
        end else if (ser_en_i && (fill_q != FW'(DW))) begin
            fill_d = fill_q + FW'(1);
        end else begin
            fill_d = fill_q;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d   = '0;
                match_cnt_d = '0;
                if (cfg_train_i) state_d = S_HUNT;
            end
            S_HUNT: begin
                if (!cfg_train_i) begin
                    state_d = S_IDLE;
                end else if (pat_hit) begin
                    bit_cnt_d   = '0;
                    match_cnt_d = 4'd1;
                    state_d     = (TRAIN_CNT == 1) ? S_LOCKED : S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (!cfg_train_i) begin
                    state_d = S_IDLE;
                end else if (ser_en_i) begin
                    bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
                    if (boundary) begin
                        if (sr_nxt == TRAIN_PAT) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_q + 4'd1 == 4'(TRAIN_CNT)) state_d = S_LOCKED;
                        end else begin
                            match_cnt_d = '0;
                            state_d     = S_HUNT;
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (ser_en_i) begin
                    bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
                    if (boundary) begin
                        dv_d  = 1'b1;
                        dat_d = sr_nxt;
                        if (cfg_train_i && (sr_nxt != TRAIN_PAT)) begin
                            bump_err    = 1'b1;
                            match_cnt_d = '0;
                            state_d     = S_HUNT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!cfg_en_i) begin
            state_d     = S_IDLE;
            fill_d      = '0;
            bit_cnt_d   = '0;
            match_cnt_d = '0;
            dv_d        = 1'b0;
            dat_d       = dat_q;
            bump_err    = 1'b0;
        end

        trained_d = (state_d == S_LOCKED);

        word_d = word_q + 32'(dv_d);
        err_d  = (bump_err && (err_q != '1)) ? err_q + 32'd1 : err_q;
        if (stat_clr_i) begin
            word_d = '0;
            err_d  = '0;
        end
    end

    always_ff @(posedge ser_clk_i) begin
        // NOTE: reset is synchronous, so it sits inside the clocked block rather than in the sensitivity list.
        if (!ser_rstn_i) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            trained_q   <= 1'b0;
            dv_q        <= 1'b0;
            dat_q       <= '0;
            word_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            match_cnt_q <= match_cnt_d;
            trained_q   <= trained_d;
            dv_q        <= dv_d;
            dat_q       <= dat_d;
            word_q      <= word_d;
            err_q       <= err_d;
        end
    end

    assign cfg_trained_o = trained_q;
    assign par_dv_o      = dv_q;
    assign par_dat_o     = dat_q;
    assign stat_word_o   = word_q;
    assign stat_err_o    = err_q;

endmodule
